exc_handler: RTL and testbench
==============================

Name: exc_handler

Overview:
- Service-side counterpart of the per-thread csr block. Watches csr_stall/ex_code/thr_id from NUM_THR thread CSRs and arbitrates pending exceptions round-robin.
- Presents one exception record at a time to the host/debug port over a valid/ready handshake.
- Waits for the host's clear command, then pulses the matching thread's clr_ex and confirms the stall has dropped.

Parameters:
- NUM_THR, 4, number of thread CSRs serviced (2..16)
- DRAIN_MAX, 4, cycles to wait for csr_stall to fall after clr_ex before re-issuing clr_ex

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- csr_stall  in  NUM_THR  per-thread stall/exception-pending from csr
- ex_code  in  NUM_THR*6  per-thread exception code; thread i at bits [6i+5:6i]
- thr_id  in  NUM_THR*8  per-thread ID; thread i at bits [8i+7:8i]
- clr_ex  out  NUM_THR  one-cycle clear pulse to thread csr
- rec_vld  out  1  exception record valid
- rec_rdy  in  1  host accepts record
- rec_thr  out  8  record thread ID
- rec_code  out  6  record exception code
- host_clr  in  1  host clear command strobe
- host_clr_id  in  8  thread ID the host is clearing
- id_err  out  1  one-cycle pulse when host_clr_id does not match the serviced thread
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: every output is 0, state=IDLE, rr_ptr=0, latched idx/thr/code=0, drain counter=0.
- Pending definition: thread i is pending when csr_stall[i]=1 and ex_code[i]!=EX_CLR. A stall with code 00 is ignored.
- IDLE: if any thread is pending, grant the first pending index at or after rr_ptr, wrapping modulo NUM_THR.
  - Latch idx, thr_id[idx] and ex_code[idx]; go to REPORT.
  - Pending seen at edge t gives rec_vld=1 after edge t+1.
- REPORT:
  - rec_vld=1; rec_thr/rec_code are held stable until the handshake.
  - On rec_vld&&rec_rdy: rec_vld falls at the next edge; go to WAIT_ACK.
- WAIT_ACK:
  - host_clr with host_clr_id==latched thr: go to CLEAR.
  - host_clr with a mismatched ID: id_err pulses for 1 cycle; state is unchanged.
  - host_clr asserted while not in WAIT_ACK: ignored, no id_err.
- CLEAR: clr_ex[idx]=1 for exactly one cycle; all other clr_ex bits stay 0. Go to DRAIN with counter=0.
- DRAIN:
  - If csr_stall[idx]=0: rr_ptr=(idx+1) mod NUM_THR; go to IDLE.
  - Otherwise counter increments. When counter reaches DRAIN_MAX-1 with the stall still high, return to CLEAR to re-pulse.
  - A new exception with a nonzero code on the same thread while in DRAIN is reported fresh after returning to IDLE.
- Multiple simultaneous pendings: serviced strictly one at a time in round-robin order. No thread is starved; worst-case wait is NUM_THR-1 services.
- Latched record: ex_code changes on the granted thread after latch do not alter rec_code.
- Reset mid-operation: rst_n=0 at any edge forces IDLE, clr_ex=0 and rec_vld=0 at that same edge. A record in flight is discarded.
- Out-of-range request: at most one clr_ex bit is ever high, and it is never driven for an index ≥ NUM_THR.

Optional Feature:
- EXC_STATS_EN defined:
  - Adds output exc_cnt[15:0]: count of completed services (DRAIN→IDLE transitions). Saturates at 16'hFFFF; reset to 0.
  - Adds output last_code[5:0]: code of the most recently completed service.
- Undefined: these ports and their registers do not exist. Core behaviour is identical in both builds.

Decomposition:
- Package exc_pkg holds:
  - Exception code constants: EX_CLR=6'h00, ALU_EX=6'h01, IL_OP=6'h05, STACK_OV=6'h0B, SEGFAULT=6'h12, BRKPT=6'h3F.
  - State enum exc_state_t: IDLE, REPORT, WAIT_ACK, CLEAR, DRAIN.
  - Record struct exc_rec_t {thr[7:0], code[5:0]}.
- Sub-module rr_arbiter (NUM_THR-wide request, rr_ptr in, one-hot grant plus index out, combinational).

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles with csr_stall=4'b1111 → all outputs 0, busy=0. Release rst_n → rec_vld=1 one cycle later with rec_thr=thr_id[0].
2. Single SEGFAULT: thread 2 stall=1, code=6'h12, id=8'h03 → rec_vld with rec_thr=8'h03, rec_code=6'h12. Then rec_rdy=1, then host_clr id=8'h03 → clr_ex=4'b0100 for one cycle. Model drops the stall → IDLE, busy=0.
3. Round-robin: threads 0,1,3 pending simultaneously with codes 01/05/3F → records emitted in order 0,1,3. Re-raise thread 0 during service of 1 → it is served after 3.
4. ID mismatch: in WAIT_ACK, host_clr id=8'h07 while serving 8'h03 → id_err pulses for 1 cycle, clr_ex stays 0. Then the correct ID → clear proceeds.
5. Drain retry: with DRAIN_MAX=4, the model ignores the first clr_ex → clr_ex re-pulses 4 cycles after DRAIN entry. The stall then drops → IDLE.
6. Mid-operation reset: assert rst_n=0 in REPORT and in CLEAR → rec_vld=0 and clr_ex=0 at that edge. With EXC_STATS_EN, exc_cnt returns to 0.

Source files
------------

// File: rtl/exc_handler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : exc_pkg
//  Description : Shared types and constants for the exception handler slice:
//                exception code values, service FSM state encoding and the
//                record presented to the host.
//  Revision    : 1.0  initial release
// ============================================================================
package exc_pkg;

    // Exception codes as raised by the per-thread csr block.
    // EX_CLR means "no exception".
    localparam logic [5:0] EX_CLR   = 6'h00;
    localparam logic [5:0] ALU_EX   = 6'h01;
    localparam logic [5:0] IL_OP    = 6'h05;
    localparam logic [5:0] STACK_OV = 6'h0B;
    localparam logic [5:0] SEGFAULT = 6'h12;
    localparam logic [5:0] BRKPT    = 6'h3F;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REPORT   = 3'd1,
        WAIT_ACK = 3'd2,
        CLEAR    = 3'd3,
        DRAIN    = 3'd4
    } exc_state_t;

    typedef struct packed {
        logic [7:0] thr;
        logic [5:0] code;
    } exc_rec_t;

endpackage
`default_nettype wire

// File: rtl/exc_handler_if.sv
`default_nettype none
// ============================================================================
//  Module      : exc_handler_if
//  Description : Host/debug port of the exception handler.
//                Record channel : rec_vld / rec_rdy / rec_thr / rec_code
//                Clear command  : host_clr / host_clr_id, id_err response
//                master = exception handler, slave = host.
//  Revision    : 1.0  initial release
// ============================================================================
interface exc_handler_if;
    logic       rec_vld;
    logic       rec_rdy;
    logic [7:0] rec_thr;
    logic [5:0] rec_code;
    logic       host_clr;
    logic [7:0] host_clr_id;
    logic       id_err;

    modport master (
        output rec_vld, rec_thr, rec_code, id_err,
        input  rec_rdy, host_clr, host_clr_id
    );

    modport slave (
        input  rec_vld, rec_thr, rec_code, id_err,
        output rec_rdy, host_clr, host_clr_id
    );
endinterface
`default_nettype wire

// File: rtl/exc_handler_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. Grants the first
//                requesting index at or after ptr, wrapping modulo NUM_THR.
//  Ports       : req  [NUM_THR-1:0]  request vector
//                ptr  [IW-1:0]       highest-priority index
//                gnt  [NUM_THR-1:0]  one-hot grant (zero when no request)
//                idx  [IW-1:0]       granted index
//                vld                 any request granted
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_THR = 4,
    parameter int IW      = $clog2(NUM_THR)
) (
    input  wire logic [NUM_THR-1:0] req,
    input  wire logic [IW-1:0]      ptr,
    output logic      [NUM_THR-1:0] gnt,
    output logic      [IW-1:0]      idx,
    output logic                    vld
);
    localparam int            IW1 = IW + 1;
    localparam logic [IW:0]   c_N = IW1'(NUM_THR);

    // Candidate position; one bit wider than ptr so ptr+k cannot overflow
    // before the modulo wrap.
    logic [IW:0] w_pos;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        vld   = 1'b0;
        w_pos = '0;
        for (int k = 0; k < NUM_THR; k++) begin
            w_pos = {1'b0, ptr} + IW1'(k);
            if (w_pos >= c_N) begin
                w_pos = w_pos - c_N;
            end
            if (!vld && req[w_pos[IW-1:0]]) begin
                vld = 1'b1;
                idx = w_pos[IW-1:0];
            end
        end
        if (vld) begin
            gnt[idx] = 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/exc_handler.sv
`default_nettype none
// ============================================================================
//  Module      : exc_handler
//  Description : Services pending exceptions from NUM_THR thread CSRs one at
//                a time in round-robin order: reports a record to the host,
//                waits for the matching clear command, pulses clr_ex to the
//                thread and waits for its stall to drop (re-pulsing after
//                DRAIN_MAX cycles if it does not).
//  Ports       : clk, rst_n (synchronous, active-low)
//                csr_stall/ex_code/thr_id  per-thread status from the CSRs
//                clr_ex                    one-cycle clear pulse per thread
//                bus (exc_handler_if.master) record + host clear port
//                busy                      FSM not in IDLE
//                exc_cnt/last_code         service statistics, only when
//                                          EXC_STATS_EN is defined
//  Revision    : 1.0  initial release
// ============================================================================
module exc_handler #(
    parameter int NUM_THR   = 4,
    parameter int DRAIN_MAX = 4
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    input  wire logic [NUM_THR-1:0]     csr_stall,
    input  wire logic [NUM_THR*6-1:0]   ex_code,
    input  wire logic [NUM_THR*8-1:0]   thr_id,
    output logic      [NUM_THR-1:0]     clr_ex,
    exc_handler_if.master               bus,
`ifdef EXC_STATS_EN
    output logic      [15:0]            exc_cnt,
    output logic      [5:0]             last_code,
`endif
    output logic                        busy
);
    import exc_pkg::*;

    localparam int IW = $clog2(NUM_THR);
    localparam int CW = $clog2(DRAIN_MAX) + 1;

    exc_state_t         r_state;
    logic [IW-1:0]      r_ptr;
    logic [IW-1:0]      r_idx;
    logic [NUM_THR-1:0] r_gnt;
    logic [NUM_THR-1:0] r_clr;
    exc_rec_t           r_rec;
    logic               r_vld;
    logic               r_id_err;
    logic               r_busy;
    logic [CW-1:0]      r_cnt;

    logic [NUM_THR-1:0] w_pend;
    logic [NUM_THR-1:0] w_gnt;
    logic [IW-1:0]      w_idx;
    logic               w_any;
    logic               w_done;

    // A stall only counts as an exception when it carries a real code.
    for (genvar i = 0; i < NUM_THR; i++) begin : g_pend
        assign w_pend[i] = csr_stall[i] && (ex_code[6*i +: 6] != EX_CLR);
    end

    rr_arbiter #(
        .NUM_THR (NUM_THR),
        .IW      (IW)
    ) u_arb (
        .req (w_pend),
        .ptr (r_ptr),
        .gnt (w_gnt),
        .idx (w_idx),
        .vld (w_any)
    );

    assign w_done = (r_state == DRAIN) && !csr_stall[r_idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_idx    <= '0;
            r_gnt    <= '0;
            r_clr    <= '0;
            r_rec    <= '0;
            r_vld    <= 1'b0;
            r_id_err <= 1'b0;
            r_busy   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            // Pulse outputs default low; set only on the cycle they fire.
            r_clr    <= '0;
            r_id_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_idx      <= w_idx;
                        r_gnt      <= w_gnt;
                        r_rec.thr  <= thr_id[w_idx*8 +: 8];
                        r_rec.code <= ex_code[w_idx*6 +: 6];
                        r_vld      <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= REPORT;
                    end
                end
                REPORT: begin
                    if (bus.rec_rdy) begin
                        r_vld   <= 1'b0;
                        r_state <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (bus.host_clr) begin
                        if (bus.host_clr_id == r_rec.thr) begin
                            r_clr   <= r_gnt;
                            r_state <= CLEAR;
                        end else begin
                            r_id_err <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    // clr_ex is high during this state only.
                    r_cnt   <= '0;
                    r_state <= DRAIN;
                end
                DRAIN: begin
                    if (!csr_stall[r_idx]) begin
                        r_ptr   <= (r_idx == IW'(NUM_THR - 1)) ? '0 : r_idx + 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (r_cnt == CW'(DRAIN_MAX - 1)) begin
                        // Thread did not react; clear it again.
                        r_clr   <= r_gnt;
                        r_state <= CLEAR;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef EXC_STATS_EN
    logic [15:0] r_exc_cnt;
    logic [5:0]  r_last_code;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_exc_cnt   <= '0;
            r_last_code <= '0;
        end else if (w_done) begin
            if (r_exc_cnt != 16'hFFFF) begin
                r_exc_cnt <= r_exc_cnt + 16'd1;
            end
            r_last_code <= r_rec.code;
        end
    end

    assign exc_cnt   = r_exc_cnt;
    assign last_code = r_last_code;
`endif

    assign clr_ex       = r_clr;
    assign busy         = r_busy;
    assign bus.rec_vld  = r_vld;
    assign bus.rec_thr  = r_rec.thr;
    assign bus.rec_code = r_rec.code;
    assign bus.id_err   = r_id_err;

endmodule
`default_nettype wire

// File: tb/tb_exc_handler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exc_handler
//  Description : Self-checking bench for exc_handler (NUM_THR=4,
//                DRAIN_MAX=4). Expected records are queued when a thread
//                exception is raised and compared when rec_vld appears.
//                Works with and without EXC_STATS_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_exc_handler;
    import exc_pkg::*;

    localparam int NT = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NT-1:0]   csr_stall = '0;
    logic [NT*6-1:0] ex_code = '0;
    logic [NT*8-1:0] thr_id = '0;
    logic [NT-1:0]   clr_ex;
    logic            busy;
`ifdef EXC_STATS_EN
    logic [15:0]     exc_cnt;
    logic [5:0]      last_code;
`endif

    exc_handler_if bus();

    int         checks = 0;
    int         errors = 0;
    int         svc_done = 0;
    logic [5:0] last_done = '0;
    exc_rec_t   exp_q[$];

    always #5 clk = ~clk;

    exc_handler #(
        .NUM_THR   (NT),
        .DRAIN_MAX (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .csr_stall (csr_stall),
        .ex_code   (ex_code),
        .thr_id    (thr_id),
        .clr_ex    (clr_ex),
        .bus       (bus),
`ifdef EXC_STATS_EN
        .exc_cnt   (exc_cnt),
        .last_code (last_code),
`endif
        .busy      (busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_thr(input int i, input logic [7:0] id, input logic [5:0] code, input logic st);
        thr_id[8*i +: 8]  = id;
        ex_code[6*i +: 6] = code;
        csr_stall[i]      = st;
    endtask

    task automatic push_exp(input logic [7:0] id, input logic [5:0] code);
        exc_rec_t r;
        r.thr  = id;
        r.code = code;
        exp_q.push_back(r);
    endtask

    task automatic apply_reset;
        csr_stall = '0;
        rst_n = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        svc_done = 0;
        last_done = '0;
        exp_q.delete();
    endtask

    task automatic wait_vld(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            tick;
            if (bus.rec_vld === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Full service of thread i, acting as host and as the thread's csr.
    // retry: csr ignores the first clr_ex; bad_id: exercise mismatched clears
    // and the latched record; raise: thread to re-raise mid-service (-1 none).
    task automatic serve(input int i, input bit retry, input bit bad_id, input int raise);
        bit            ok;
        exc_rec_t      e;
        logic [NT-1:0] oh;
        oh = '0;
        oh[i] = 1'b1;
        e = '0;
        wait_vld(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rec_vld_timeout thr_idx=%0d got rec_vld=0 expected 1", i);
            return;
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty got record thr=%h expected none", bus.rec_thr);
        end else begin
            e = exp_q.pop_front();
        end
        checks++;
        if (bus.rec_thr !== e.thr) begin
            errors++;
            $display("FAIL rec_thr got %h expected %h", bus.rec_thr, e.thr);
        end
        checks++;
        if (bus.rec_code !== e.code) begin
            errors++;
            $display("FAIL rec_code got %h expected %h", bus.rec_code, e.code);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_report got %b expected 1", busy);
        end
        if (bad_id) begin
            // Clear command and code change while still in REPORT.
            ex_code[6*i +: 6] = BRKPT;
            bus.host_clr = 1'b1;
            bus.host_clr_id = 8'h07;
            tick;
            bus.host_clr = 1'b0;
            checks++;
            if (bus.id_err !== 1'b0) begin
                errors++;
                $display("FAIL id_err_outside_wait got %b expected 0", bus.id_err);
            end
            checks++;
            if (bus.rec_code !== e.code || bus.rec_vld !== 1'b1) begin
                errors++;
                $display("FAIL latched_record got code=%h vld=%b expected code=%h vld=1", bus.rec_code, bus.rec_vld, e.code);
            end
        end
        bus.rec_rdy = 1'b1;
        tick;
        bus.rec_rdy = 1'b0;
        checks++;
        if (bus.rec_vld !== 1'b0) begin
            errors++;
            $display("FAIL rec_vld_after_hs got %b expected 0", bus.rec_vld);
        end
        if (raise >= 0) begin
            ex_code[6*raise +: 6] = STACK_OV;
            csr_stall[raise] = 1'b1;
            push_exp(thr_id[8*raise +: 8], STACK_OV);
        end
        if (bad_id) begin
            bus.host_clr = 1'b1;
            bus.host_clr_id = 8'h07;
            tick;
            bus.host_clr = 1'b0;
            checks++;
            if (bus.id_err !== 1'b1 || clr_ex !== '0) begin
                errors++;
                $display("FAIL id_err_pulse got id_err=%b clr_ex=%b expected 1/0000", bus.id_err, clr_ex);
            end
            tick;
            checks++;
            if (bus.id_err !== 1'b0 || busy !== 1'b1 || clr_ex !== '0) begin
                errors++;
                $display("FAIL id_err_width got id_err=%b busy=%b clr_ex=%b expected 0/1/0000", bus.id_err, busy, clr_ex);
            end
        end
        bus.host_clr = 1'b1;
        bus.host_clr_id = e.thr;
        tick;
        bus.host_clr = 1'b0;
        checks++;
        if (clr_ex !== oh || bus.id_err !== 1'b0) begin
            errors++;
            $display("FAIL clr_ex_pulse got clr_ex=%b id_err=%b expected %b/0", clr_ex, bus.id_err, oh);
        end
        if (retry) begin
            for (int n = 0; n < 4; n++) begin
                tick;
                checks++;
                if (clr_ex !== '0) begin
                    errors++;
                    $display("FAIL clr_ex_drain_gap cycle %0d got %b expected 0000", n, clr_ex);
                end
            end
            tick;
            checks++;
            if (clr_ex !== oh) begin
                errors++;
                $display("FAIL clr_ex_repulse got %b expected %b", clr_ex, oh);
            end
        end
        csr_stall[i] = 1'b0;
        tick;
        checks++;
        if (clr_ex !== '0) begin
            errors++;
            $display("FAIL clr_ex_width got %b expected 0000", clr_ex);
        end
        tick;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_drain got %b expected 0", busy);
        end
        svc_done++;
        last_done = e.code;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int i = 0; i < NT; i++) begin
            set_thr(i, 8'h10 + 8'(i), ALU_EX, 1'b1);
        end
        tick;
        tick;
        checks++;
        if (bus.rec_vld !== 1'b0 || clr_ex !== '0 || bus.id_err !== 1'b0 || busy !== 1'b0
            || bus.rec_thr !== 8'h00 || bus.rec_code !== 6'h00) begin
            errors++;
            $display("FAIL reset_outputs got vld=%b clr=%b iderr=%b busy=%b thr=%h code=%h expected all 0",
                     bus.rec_vld, clr_ex, bus.id_err, busy, bus.rec_thr, bus.rec_code);
        end
`ifdef EXC_STATS_EN
        checks++;
        if (exc_cnt !== 16'd0 || last_code !== 6'd0) begin
            errors++;
            $display("FAIL reset_stats got cnt=%0d last=%h expected 0/00", exc_cnt, last_code);
        end
`endif
        rst_n = 1'b1;
        tick;
        checks++;
        if (bus.rec_vld !== 1'b1 || bus.rec_thr !== 8'h10) begin
            errors++;
            $display("FAIL reset_release_grant got vld=%b thr=%h expected 1/10", bus.rec_vld, bus.rec_thr);
        end
        apply_reset;
    endtask

    task automatic test_single;
        set_thr(2, 8'h03, SEGFAULT, 1'b1);
        push_exp(8'h03, SEGFAULT);
        serve(2, 1'b0, 1'b0, -1);
`ifdef EXC_STATS_EN
        checks++;
        if (exc_cnt !== 16'(svc_done) || last_code !== last_done) begin
            errors++;
            $display("FAIL stats_single got cnt=%0d last=%h expected %0d/%h", exc_cnt, last_code, svc_done, last_done);
        end
`endif
    endtask

    task automatic test_round_robin;
        apply_reset;
        set_thr(0, 8'h30, ALU_EX, 1'b1);
        set_thr(1, 8'h31, IL_OP, 1'b1);
        set_thr(3, 8'h33, BRKPT, 1'b1);
        push_exp(8'h30, ALU_EX);
        push_exp(8'h31, IL_OP);
        push_exp(8'h33, BRKPT);
        serve(0, 1'b0, 1'b0, -1);
        serve(1, 1'b0, 1'b0, 0);
        serve(3, 1'b0, 1'b0, -1);
        serve(0, 1'b0, 1'b0, -1);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rr_leftover got %0d queued records expected 0", exp_q.size());
        end
    endtask

    task automatic test_id_mismatch;
        set_thr(2, 8'h03, STACK_OV, 1'b1);
        push_exp(8'h03, STACK_OV);
        serve(2, 1'b0, 1'b1, -1);
    endtask

    task automatic test_drain_retry;
        set_thr(1, 8'h21, IL_OP, 1'b1);
        push_exp(8'h21, IL_OP);
        serve(1, 1'b1, 1'b0, -1);
`ifdef EXC_STATS_EN
        checks++;
        if (exc_cnt !== 16'(svc_done) || last_code !== IL_OP) begin
            errors++;
            $display("FAIL stats_retry got cnt=%0d last=%h expected %0d/%h", exc_cnt, last_code, svc_done, IL_OP);
        end
`endif
    endtask

    task automatic test_mid_reset;
        bit ok;
        set_thr(3, 8'h43, SEGFAULT, 1'b1);
        wait_vld(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL mid_reset_vld_timeout got rec_vld=0 expected 1");
        end
        rst_n = 1'b0;
        tick;
        checks++;
        if (bus.rec_vld !== 1'b0 || busy !== 1'b0 || clr_ex !== '0) begin
            errors++;
            $display("FAIL reset_in_report got vld=%b busy=%b clr=%b expected 0/0/0000", bus.rec_vld, busy, clr_ex);
        end
`ifdef EXC_STATS_EN
        checks++;
        if (exc_cnt !== 16'd0) begin
            errors++;
            $display("FAIL stats_reset got cnt=%0d expected 0", exc_cnt);
        end
`endif
        rst_n = 1'b1;
        wait_vld(ok);
        checks++;
        if (!ok || bus.rec_thr !== 8'h43 || bus.rec_code !== SEGFAULT) begin
            errors++;
            $display("FAIL fresh_after_reset got vld=%b thr=%h code=%h expected 1/43/12", bus.rec_vld, bus.rec_thr, bus.rec_code);
        end
        bus.rec_rdy = 1'b1;
        tick;
        bus.rec_rdy = 1'b0;
        bus.host_clr = 1'b1;
        bus.host_clr_id = 8'h43;
        tick;
        bus.host_clr = 1'b0;
        checks++;
        if (clr_ex !== 4'b1000) begin
            errors++;
            $display("FAIL clr_before_reset got %b expected 1000", clr_ex);
        end
        rst_n = 1'b0;
        tick;
        checks++;
        if (clr_ex !== '0 || busy !== 1'b0 || bus.rec_vld !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_clear got clr=%b busy=%b vld=%b expected 0000/0/0", clr_ex, busy, bus.rec_vld);
        end
        csr_stall = '0;
        rst_n = 1'b1;
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rec_rdy     = 1'b0;
        bus.host_clr    = 1'b0;
        bus.host_clr_id = 8'h00;
        test_reset;
        test_single;
        test_round_robin;
        test_id_mismatch;
        test_drain_retry;
        test_mid_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
